// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI receive deserializer with a show-ahead receive FIFO.
//
// While ss is low, mosi is sampled on every rising clk edge and assembled
// MSB-first into WIDTH-bit words. Each completed word goes straight into a
// DEPTH-entry FIFO on the edge that samples its last bit.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   ss, mosi       active-low slave select and serial data from spi_master
//   rd_en          pop request (ignored while empty)
//   rd_data        head-of-FIFO word, valid while empty=0
//   empty, full    FIFO holds 0 / DEPTH words
//   level          number of words held
//   busy           a frame is partly received
//   frame_err      one-cycle pulse when ss rises mid-frame
//   overflow       sticky; a completed word was dropped because FIFO was full
//   ovf_clr        clears overflow (a coincident drop keeps it set)
//   par_err        (SPI_RX_PARITY_EN only) one-cycle pulse on parity mismatch
//
// Optional build macro SPI_RX_PARITY_EN: each word is followed by an even
// parity bit; the word is pushed on the parity edge only if parity matches.
module spi_slave_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ss,
  input  logic                     mosi,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     overflow,
  input  logic                     ovf_clr
`ifdef SPI_RX_PARITY_EN
  ,
  output logic                     par_err
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

`ifdef SPI_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic              push;
  logic              pop;
  logic              can_write;
  logic [WIDTH-1:0]  push_word;
  logic [CW-1:0]     bit_idx;

  assign empty     = (level == '0);
  assign full      = (level == LW'(DEPTH));
  assign busy      = (state != IDLE);
  assign rd_data   = mem[rd_ptr];
  assign pop       = rd_en && !empty;
  // A pop on the same edge frees the slot the push needs.
  assign can_write = !full || pop;
  assign bit_idx   = CW'(WIDTH - 1) - cnt;

  always_comb begin
    push      = 1'b0;
    push_word = shreg;
`ifdef SPI_RX_PARITY_EN
    // Data bits are already complete in shreg; mosi is the parity bit.
    if (state == PARITY && !ss) begin
      push = (mosi == ^shreg);
    end
`else
    // Last data bit bypasses the shift register so the push has no latency.
    push_word[0] = mosi;
    if (state == SHIFT && !ss && cnt == CW'(WIDTH - 1)) begin
      push = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
`ifdef SPI_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      frame_err <= 1'b0;
`ifdef SPI_RX_PARITY_EN
      par_err   <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (!ss) begin
            shreg[WIDTH-1] <= mosi;
            cnt            <= CW'(1);
            state          <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss) begin
            frame_err <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end else if (cnt == CW'(WIDTH - 1)) begin
            cnt <= '0;
`ifdef SPI_RX_PARITY_EN
            shreg[0] <= mosi;
            state    <= PARITY;
`else
            state    <= IDLE;
`endif
          end else begin
            shreg[bit_idx] <= mosi;
            cnt            <= cnt + CW'(1);
          end
        end
`ifdef SPI_RX_PARITY_EN
        PARITY: begin
          state <= IDLE;
          if (ss) begin
            frame_err <= 1'b1;
          end else if (mosi != ^shreg) begin
            par_err <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase

      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && can_write) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + PW'(1);
      end

      if (push && !can_write) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end

      case ({push && can_write, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: directed scenarios plus a randomized
// phase, compared every cycle against a queue-based behavioural model.
module tb_spi_slave_rx;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int unsigned MASK = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ss = 1'b1;
  logic mosi = 1'b0;
  logic rd_en = 1'b0;
  logic ovf_clr = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic empty, full, busy, frame_err, overflow;
  logic [$clog2(DEPTH):0] level;
`ifdef SPI_RX_PARITY_EN
  logic par_err;
`endif

  always #5 clk = ~clk;

  spi_slave_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ss(ss), .mosi(mosi), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .level(level),
    .busy(busy), .frame_err(frame_err), .overflow(overflow),
    .ovf_clr(ovf_clr)
`ifdef SPI_RX_PARITY_EN
    , .par_err(par_err)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: bits accumulate into an integer, words go into a queue.
  int unsigned q[$];
  int unsigned m_nbits = 0;
  int unsigned m_acc = 0;
  int unsigned m_word = 0;
  bit m_in_par = 0;
  bit m_ferr = 0, m_perr = 0, m_ovf = 0;
  bit m_pop, m_have, m_drop;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_nbits = 0; m_acc = 0; m_in_par = 0;
      m_ferr = 0; m_perr = 0; m_ovf = 0;
    end else begin
      m_pop  = rd_en && (q.size() != 0);
      m_have = 0;
      m_drop = 0;
      m_ferr = 0;
      m_perr = 0;
      if (ss) begin
        if (m_nbits != 0 || m_in_par) m_ferr = 1;
        m_nbits = 0;
        m_in_par = 0;
      end else if (m_in_par) begin
        m_in_par = 0;
        if ((($countones(m_acc) + int'(mosi)) % 2) == 0) begin
          m_have = 1;
          m_word = m_acc;
        end else begin
          m_perr = 1;
        end
      end else begin
        m_acc = ((m_acc << 1) | int'(mosi)) & MASK;
        m_nbits++;
        if (m_nbits == WIDTH) begin
          m_nbits = 0;
`ifdef SPI_RX_PARITY_EN
          m_in_par = 1;
`else
          m_have = 1;
          m_word = m_acc;
`endif
        end
      end
      if (m_pop) void'(q.pop_front());
      if (m_have) begin
        if (q.size() < DEPTH) q.push_back(m_word);
        else m_drop = 1;
      end
      if (m_drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
    end
  end

  bit chk_en = 0;
  int ferr_seen = 0;
  int perr_seen = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("empty", empty, q.size() == 0);
      check("full", full, q.size() == DEPTH);
      check("level", level, q.size());
      check("busy", busy, (m_nbits != 0) || m_in_par);
      check("frame_err", frame_err, m_ferr);
      check("overflow", overflow, m_ovf);
      if (q.size() != 0) check("rd_data", rd_data, q[0]);
      if (frame_err === 1'b1) ferr_seen++;
`ifdef SPI_RX_PARITY_EN
      check("par_err", par_err, m_perr);
      if (par_err === 1'b1) perr_seen++;
`endif
    end
  end

  // Entered and left at a falling edge; ss stays low on return.
  task automatic send(input logic [WIDTH-1:0] w, input int nb, input bit pop_last, input bit par_flip);
    int total;
    total = nb;
`ifdef SPI_RX_PARITY_EN
    if (nb == WIDTH) total = WIDTH + 1;
`endif
    for (int i = 0; i < total; i++) begin
      ss = 1'b0;
      if (i < WIDTH) mosi = w[WIDTH-1-i];
      else mosi = (^w) ^ par_flip;
      rd_en = pop_last && (i == total - 1);
      @(negedge clk);
    end
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    ss = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_expect(input logic [WIDTH-1:0] e, input string nm);
    check(nm, rd_data, e);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  int f0, p0;
  logic [WIDTH-1:0] vals [4];

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("reset_rd_data", rd_data, 0);
    check("reset_empty", empty, 1);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    idle(1);

    // Basic receive of A5
    f0 = ferr_seen;
    send(8'hA5, WIDTH, 0, 0);
    check("basic_rd_data", rd_data, 8'hA5);
    check("basic_level", level, 1);
    idle(2);
    check("basic_no_ferr", ferr_seen - f0, 0);
    pop_expect(8'hA5, "basic_pop");

    // Back-to-back 3C, C3
    send(8'h3C, WIDTH, 0, 0);
    check("b2b_boundary_busy", busy, 0);
    send(8'hC3, WIDTH, 0, 0);
    idle(1);
    check("b2b_level", level, 2);
    pop_expect(8'h3C, "b2b_pop0");
    pop_expect(8'hC3, "b2b_pop1");

    // Truncated frame then 81
    f0 = ferr_seen;
    send(8'hF0, 5, 0, 0);
    idle(3);
    check("trunc_ferr_pulses", ferr_seen - f0, 1);
    check("trunc_level", level, 0);
    send(8'h81, WIDTH, 0, 0);
    idle(1);
    pop_expect(8'h81, "trunc_next");

    // Overflow
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      send(vals[i], WIDTH, 0, 0);
      idle(1);
    end
    check("ovf_full", full, 1);
    check("ovf_not_yet", overflow, 0);
    send(8'h55, WIDTH, 0, 0);
    idle(1);
    check("ovf_set", overflow, 1);
    check("ovf_level", level, 4);
    for (int i = 0; i < 4; i++) pop_expect(vals[i], "ovf_pop");
    check("ovf_empty", empty, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Push and pop on the same edge while full
    vals[0] = 8'h61; vals[1] = 8'h62; vals[2] = 8'h63; vals[3] = 8'h64;
    for (int i = 0; i < 4; i++) begin
      send(vals[i], WIDTH, 0, 0);
      idle(1);
    end
    send(8'h66, WIDTH, 1, 0);
    check("pp_no_ovf", overflow, 0);
    check("pp_level", level, 4);
    check("pp_full", full, 1);
    idle(1);
    pop_expect(8'h62, "pp_pop0");
    pop_expect(8'h63, "pp_pop1");
    pop_expect(8'h64, "pp_pop2");
    pop_expect(8'h66, "pp_pop3");

    // Reset mid-frame with a word held
    send(8'h77, WIDTH, 0, 0);
    idle(1);
    f0 = ferr_seen;
    send(8'hE0, 3, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ss = 1'b1;
    check("rst_empty", empty, 1);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_frame_err", frame_err, 0);
    idle(2);
    check("rst_no_ferr", ferr_seen - f0, 0);
    send(8'h5A, WIDTH, 0, 0);
    idle(1);
    pop_expect(8'h5A, "rst_next");
`ifdef SPI_RX_PARITY_EN
    p0 = perr_seen;
    send(8'h5A, WIDTH, 0, 1);
    idle(2);
    check("par_err_pulses", perr_seen - p0, 1);
    check("par_level", level, 0);
`endif

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      rst     = ($urandom_range(0, 499) == 0);
      ss      = ($urandom_range(0, 15) == 0);
      mosi    = 1'($urandom_range(0, 1));
      rd_en   = (c < 2000) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
      ovf_clr = ($urandom_range(0, 19) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    rd_en = 1'b0;
    ovf_clr = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
